// File: rtl/axi4lite_arb2.sv
// Two-to-one AXI4-Lite arbiter: one outstanding transaction in total, round-robin
// between masters, channels forwarded combinationally from the registered grant.
module axi4lite_arb2 #(
    parameter int A_WIDTH = 32,
    parameter int D_WIDTH = 32
) (
    input  logic                   aclk,
    input  logic                   areset,
    // requester 0
    input  logic [A_WIDTH-1:0]     s0_awaddr_i,
    input  logic [2:0]             s0_awprot_i,
    input  logic                   s0_awvalid_i,
    output logic                   s0_awready_o,
    input  logic [D_WIDTH-1:0]     s0_wdata_i,
    input  logic [D_WIDTH/8-1:0]   s0_wstrb_i,
    input  logic                   s0_wvalid_i,
    output logic                   s0_wready_o,
    output logic [1:0]             s0_bresp_o,
    output logic                   s0_bvalid_o,
    input  logic                   s0_bready_i,
    input  logic [A_WIDTH-1:0]     s0_araddr_i,
    input  logic [2:0]             s0_arprot_i,
    input  logic                   s0_arvalid_i,
    output logic                   s0_arready_o,
    output logic [D_WIDTH-1:0]     s0_rdata_o,
    output logic [1:0]             s0_rresp_o,
    output logic                   s0_rvalid_o,
    input  logic                   s0_rready_i,
    // requester 1
    input  logic [A_WIDTH-1:0]     s1_awaddr_i,
    input  logic [2:0]             s1_awprot_i,
    input  logic                   s1_awvalid_i,
    output logic                   s1_awready_o,
    input  logic [D_WIDTH-1:0]     s1_wdata_i,
    input  logic [D_WIDTH/8-1:0]   s1_wstrb_i,
    input  logic                   s1_wvalid_i,
    output logic                   s1_wready_o,
    output logic [1:0]             s1_bresp_o,
    output logic                   s1_bvalid_o,
    input  logic                   s1_bready_i,
    input  logic [A_WIDTH-1:0]     s1_araddr_i,
    input  logic [2:0]             s1_arprot_i,
    input  logic                   s1_arvalid_i,
    output logic                   s1_arready_o,
    output logic [D_WIDTH-1:0]     s1_rdata_o,
    output logic [1:0]             s1_rresp_o,
    output logic                   s1_rvalid_o,
    input  logic                   s1_rready_i,
    // shared downstream slave
    output logic [A_WIDTH-1:0]     m_awaddr_o,
    output logic [2:0]             m_awprot_o,
    output logic                   m_awvalid_o,
    input  logic                   m_awready_i,
    output logic [D_WIDTH-1:0]     m_wdata_o,
    output logic [D_WIDTH/8-1:0]   m_wstrb_o,
    output logic                   m_wvalid_o,
    input  logic                   m_wready_i,
    input  logic [1:0]             m_bresp_i,
    input  logic                   m_bvalid_i,
    output logic                   m_bready_o,
    output logic [A_WIDTH-1:0]     m_araddr_o,
    output logic [2:0]             m_arprot_o,
    output logic                   m_arvalid_o,
    input  logic                   m_arready_i,
    input  logic [D_WIDTH-1:0]     m_rdata_i,
    input  logic [1:0]             m_rresp_i,
    input  logic                   m_rvalid_i,
    output logic                   m_rready_o,
    // debug view of the arbiter state
    output logic [2:0]             state_o,
    output logic                   grant_o,
    output logic                   last_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t state_q;
    logic   grant_q, last_q, aw_done_q, w_done_q;
    logic   grant_d, win_wr;

    logic wreq0, wreq1, req0, req1;
    logic st_wa, st_wr, st_ra, st_rd;
    logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
    logic aw_rdy, w_rdy, ar_rdy, b_vld, r_vld;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign wreq0 = s0_awvalid_i | s0_wvalid_i;
    assign wreq1 = s1_awvalid_i | s1_wvalid_i;
    assign req0  = wreq0 | s0_arvalid_i;
    assign req1  = wreq1 | s1_arvalid_i;

    assign st_wa = (state_q == WR_ADDR);
    assign st_wr = (state_q == WR_RESP);
    assign st_ra = (state_q == RD_ADDR);
    assign st_rd = (state_q == RD_DATA);

    // Payload always follows the registered grant; only valids/readies are gated.
    assign m_awaddr_o = grant_q ? s1_awaddr_i : s0_awaddr_i;
    assign m_awprot_o = grant_q ? s1_awprot_i : s0_awprot_i;
    assign m_wdata_o  = grant_q ? s1_wdata_i  : s0_wdata_i;
    assign m_wstrb_o  = grant_q ? s1_wstrb_i  : s0_wstrb_i;
    assign m_araddr_o = grant_q ? s1_araddr_i : s0_araddr_i;
    assign m_arprot_o = grant_q ? s1_arprot_i : s0_arprot_i;

    assign g_awvalid = grant_q ? s1_awvalid_i : s0_awvalid_i;
    assign g_wvalid  = grant_q ? s1_wvalid_i  : s0_wvalid_i;
    assign g_bready  = grant_q ? s1_bready_i  : s0_bready_i;
    assign g_arvalid = grant_q ? s1_arvalid_i : s0_arvalid_i;
    assign g_rready  = grant_q ? s1_rready_i  : s0_rready_i;

    // A transfer happens on a channel in the cycle where valid and ready are both
    // high at the rising edge; valid never waits on ready, ready may wait on valid.
    assign m_awvalid_o = st_wa & g_awvalid & ~aw_done_q;
    assign aw_rdy      = st_wa & m_awready_i & ~aw_done_q;
    assign m_wvalid_o  = st_wa & g_wvalid & ~w_done_q;
    assign w_rdy       = st_wa & m_wready_i & ~w_done_q;
    assign m_bready_o  = st_wr & g_bready;
    assign b_vld       = st_wr & m_bvalid_i;
    assign m_arvalid_o = st_ra & g_arvalid;
    assign ar_rdy      = st_ra & m_arready_i;
    assign m_rready_o  = st_rd & g_rready;
    assign r_vld       = st_rd & m_rvalid_i;

    assign s0_awready_o = aw_rdy & ~grant_q;
    assign s1_awready_o = aw_rdy &  grant_q;
    assign s0_wready_o  = w_rdy  & ~grant_q;
    assign s1_wready_o  = w_rdy  &  grant_q;
    assign s0_bvalid_o  = b_vld  & ~grant_q;
    assign s1_bvalid_o  = b_vld  &  grant_q;
    assign s0_arready_o = ar_rdy & ~grant_q;
    assign s1_arready_o = ar_rdy &  grant_q;
    assign s0_rvalid_o  = r_vld  & ~grant_q;
    assign s1_rvalid_o  = r_vld  &  grant_q;

    assign s0_bresp_o = m_bresp_i;
    assign s1_bresp_o = m_bresp_i;
    assign s0_rdata_o = m_rdata_i;
    assign s1_rdata_o = m_rdata_i;
    assign s0_rresp_o = m_rresp_i;
    assign s1_rresp_o = m_rresp_i;

    assign aw_hs = m_awvalid_o & m_awready_i;
    assign w_hs  = m_wvalid_o  & m_wready_i;
    assign b_hs  = m_bvalid_i  & m_bready_o;
    assign ar_hs = m_arvalid_o & m_arready_i;
    assign r_hs  = m_rvalid_i  & m_rready_o;

    // On a tie the master that was not granted last time wins.
    always_comb begin
        grant_d = 1'b0;
        if (req0 & req1) begin
            grant_d = ~last_q;
        end else begin
            grant_d = req1;
        end
        win_wr = grant_d ? wreq1 : wreq0;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 | req1) begin
                        grant_q <= grant_d;
                        last_q  <= grant_d;
                        state_q <= win_wr ? WR_ADDR : RD_ADDR;
                    end
                end
                WR_ADDR: begin
                    if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                        state_q   <= WR_RESP;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        if (aw_hs) aw_done_q <= 1'b1;
                        if (w_hs)  w_done_q  <= 1'b1;
                    end
                end
                WR_RESP: if (b_hs)  state_q <= IDLE;
                RD_ADDR: if (ar_hs) state_q <= RD_DATA;
                RD_DATA: if (r_hs)  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_o = state_q;
    assign grant_o = grant_q;
    assign last_o  = last_q;

endmodule

// File: tb/tb_axi4lite_arb2.sv
// Directed bench for axi4lite_arb2: a downstream monitor pops an expected-transaction
// queue filled as stimulus is driven; master-side responses are checked in line.
module tb_axi4lite_arb2;

    localparam int SB_W = 65;
    localparam logic [2:0] S_IDLE = 3'd0, S_WA = 3'd1, S_WR = 3'd2, S_RA = 3'd3, S_RD = 3'd4;

    logic aclk = 1'b0;
    logic areset = 1'b1;

    logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata;
    logic [2:0]  s0_awprot, s0_arprot;
    logic [3:0]  s0_wstrb;
    logic [1:0]  s0_bresp, s0_rresp;
    logic s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
    logic s0_arvalid, s0_arready, s0_rvalid, s0_rready;

    logic [31:0] s1_awaddr, s1_wdata, s1_araddr, s1_rdata;
    logic [2:0]  s1_awprot, s1_arprot;
    logic [3:0]  s1_wstrb;
    logic [1:0]  s1_bresp, s1_rresp;
    logic s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
    logic s1_arvalid, s1_arready, s1_rvalid, s1_rready;

    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic m_arvalid, m_arready, m_rvalid, m_rready;

    logic [2:0] state;
    logic       grant, last;

    int n_tests = 0;
    int n_fail = 0;
    int aw_hs_cnt = 0;
    int w_hs_cnt = 0;
    logic [SB_W-1:0] exp_q[$];

    axi4lite_arb2 #(.A_WIDTH(32), .D_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset),
        .s0_awaddr_i(s0_awaddr), .s0_awprot_i(s0_awprot), .s0_awvalid_i(s0_awvalid), .s0_awready_o(s0_awready),
        .s0_wdata_i(s0_wdata), .s0_wstrb_i(s0_wstrb), .s0_wvalid_i(s0_wvalid), .s0_wready_o(s0_wready),
        .s0_bresp_o(s0_bresp), .s0_bvalid_o(s0_bvalid), .s0_bready_i(s0_bready),
        .s0_araddr_i(s0_araddr), .s0_arprot_i(s0_arprot), .s0_arvalid_i(s0_arvalid), .s0_arready_o(s0_arready),
        .s0_rdata_o(s0_rdata), .s0_rresp_o(s0_rresp), .s0_rvalid_o(s0_rvalid), .s0_rready_i(s0_rready),
        .s1_awaddr_i(s1_awaddr), .s1_awprot_i(s1_awprot), .s1_awvalid_i(s1_awvalid), .s1_awready_o(s1_awready),
        .s1_wdata_i(s1_wdata), .s1_wstrb_i(s1_wstrb), .s1_wvalid_i(s1_wvalid), .s1_wready_o(s1_wready),
        .s1_bresp_o(s1_bresp), .s1_bvalid_o(s1_bvalid), .s1_bready_i(s1_bready),
        .s1_araddr_i(s1_araddr), .s1_arprot_i(s1_arprot), .s1_arvalid_i(s1_arvalid), .s1_arready_o(s1_arready),
        .s1_rdata_o(s1_rdata), .s1_rresp_o(s1_rresp), .s1_rvalid_o(s1_rvalid), .s1_rready_i(s1_rready),
        .m_awaddr_o(m_awaddr), .m_awprot_o(m_awprot), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
        .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
        .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready),
        .m_araddr_o(m_araddr), .m_arprot_o(m_arprot), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
        .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready),
        .state_o(state), .grant_o(grant), .last_o(last)
    );

    // clock
    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [SB_W-1:0] obs, input logic [SB_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input logic [SB_W-1:0] got);
        n_tests++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_unexpected: observed %0h expected none", got);
        end
        if (exp_q.size() != 0) check("sb_txn", got, exp_q.pop_front());
    endtask

    // downstream monitor: a handshake seen mid-cycle completes at the next edge
    logic        have_aw = 1'b0, have_w = 1'b0;
    logic [31:0] mon_addr, mon_data;
    always @(negedge aclk) begin
        if (!areset) begin
            if (m_awvalid && m_awready) begin
                aw_hs_cnt++;
                have_aw = 1'b1;
                mon_addr = m_awaddr;
            end
            if (m_wvalid && m_wready) begin
                w_hs_cnt++;
                have_w = 1'b1;
                mon_data = m_wdata;
            end
            if (have_aw && have_w) begin
                sb_pop({1'b1, mon_addr, mon_data});
                have_aw = 1'b0;
                have_w = 1'b0;
            end
            if (m_arvalid && m_arready) sb_pop({1'b0, m_araddr, 32'h0});
        end
    end

    task automatic nxt;
        @(posedge aclk);
        #1;
    endtask

    task automatic mid;
        @(negedge aclk);
    endtask

    task automatic do_reset;
        areset = 1'b1;
        nxt;
        nxt;
        areset = 1'b0;
        mid;
    endtask

    task automatic chk_quiet(input string tag, input logic who);
        if (who) check(tag, {s1_awready, s1_wready, s1_arready, s1_bvalid, s1_rvalid}, 0);
        else     check(tag, {s0_awready, s0_wready, s0_arready, s0_bvalid, s0_rvalid}, 0);
    endtask

    // Entered at the WR_ADDR cycle whose edge completes the address/data phase.
    task automatic finish_write(input logic who, input logic [1:0] resp);
        nxt;
        if (who) begin s1_awvalid = 0; s1_wvalid = 0; s1_bready = 1; end
        else     begin s0_awvalid = 0; s0_wvalid = 0; s0_bready = 1; end
        m_bvalid = 1;
        m_bresp = resp;
        mid;
        check("wr_state", state, S_WR);
        check("wr_bvalid", {s1_bvalid, s0_bvalid}, who ? 2'b10 : 2'b01);
        check("wr_bresp", who ? s1_bresp : s0_bresp, resp);
        check("wr_no_ar", m_arvalid, 0);
        nxt;
        m_bvalid = 0;
        s0_bready = 0;
        s1_bready = 0;
        mid;
        check("wr_idle", state, S_IDLE);
    endtask

    // Entered at the RD_ADDR cycle whose edge completes the AR handshake.
    task automatic finish_read(input logic who, input logic [1:0] resp);
        logic [31:0] rd;
        rd = $urandom;
        nxt;
        if (who) begin s1_arvalid = 0; s1_rready = 1; end
        else     begin s0_arvalid = 0; s0_rready = 1; end
        m_rvalid = 1;
        m_rdata = rd;
        m_rresp = resp;
        mid;
        check("rd_state", state, S_RD);
        check("rd_rvalid", {s1_rvalid, s0_rvalid}, who ? 2'b10 : 2'b01);
        check("rd_rdata", who ? s1_rdata : s0_rdata, rd);
        check("rd_rresp", who ? s1_rresp : s0_rresp, resp);
        nxt;
        m_rvalid = 0;
        s0_rready = 0;
        s1_rready = 0;
        mid;
        check("rd_idle", state, S_IDLE);
    endtask

    initial begin
        logic [31:0] d;
        int a0, w0;
        s0_awaddr = 32'h1234; s0_awprot = 3'b000; s0_awvalid = 0; s0_wdata = 0; s0_wstrb = 0; s0_wvalid = 0;
        s0_bready = 0; s0_araddr = 0; s0_arprot = 3'b000; s0_arvalid = 0; s0_rready = 0;
        s1_awaddr = 32'h5678; s1_awprot = 3'b010; s1_awvalid = 0; s1_wdata = 0; s1_wstrb = 0; s1_wvalid = 0;
        s1_bready = 0; s1_araddr = 0; s1_arprot = 3'b010; s1_arvalid = 0; s1_rready = 0;
        m_awready = 1; m_wready = 1; m_arready = 1; m_bresp = 0; m_bvalid = 0;
        m_rdata = 0; m_rresp = 0; m_rvalid = 0;

        // reset state
        do_reset;
        check("rst_state", state, S_IDLE);
        check("rst_grant", grant, 0);
        check("rst_last", last, 1);
        check("rst_m_ctrl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        chk_quiet("rst_s0", 0);
        chk_quiet("rst_s1", 1);
        check("rst_payload", m_awaddr, 32'h1234);

        // single write from s0
        nxt;
        s0_awaddr = 32'h10; s0_awvalid = 1; s0_wdata = 32'hA5A5_0001; s0_wstrb = 4'hF; s0_wvalid = 1;
        exp_q.push_back({1'b1, 32'h10, 32'hA5A5_0001});
        mid;
        check("t1_idle", state, S_IDLE);
        check("t1_no_comb_aw", m_awvalid, 0);
        nxt;
        mid;
        check("t1_wa_state", state, S_WA);
        check("t1_awvalid", {m_awvalid, m_wvalid}, 2'b11);
        check("t1_awaddr", m_awaddr, 32'h10);
        check("t1_wstrb", m_wstrb, 4'hF);
        check("t1_s0_ready", {s0_awready, s0_wready}, 2'b11);
        chk_quiet("t1_s1_quiet", 1);
        finish_write(0, 2'b00);

        // simultaneous s0 read and s1 write straight after reset
        do_reset;
        nxt;
        d = $urandom;
        s0_araddr = 32'h20; s0_arvalid = 1;
        s1_awaddr = 32'h30; s1_awvalid = 1; s1_wdata = d; s1_wstrb = 4'hF; s1_wvalid = 1;
        exp_q.push_back({1'b0, 32'h20, 32'h0});
        exp_q.push_back({1'b1, 32'h30, d});
        mid;
        nxt;
        mid;
        check("t2_rd_first", {state, grant}, {S_RA, 1'b0});
        check("t2_araddr", m_araddr, 32'h20);
        check("t2_s0_arready", s0_arready, 1);
        chk_quiet("t2_s1_wait", 1);
        finish_read(0, 2'b10);
        check("t2_last0", last, 0);
        nxt;
        mid;
        check("t2_wr_second", {state, grant}, {S_WA, 1'b1});
        check("t2_awaddr", m_awaddr, 32'h30);
        check("t2_awprot", m_awprot, 3'b010);
        check("t2_s1_awready", s1_awready, 1);
        chk_quiet("t2_s0_quiet", 0);
        finish_write(1, 2'b11);
        check("t2_last1", last, 1);
        // tie again: s0 wins
        nxt;
        s0_araddr = 32'h24; s0_arvalid = 1;
        s1_araddr = 32'h34; s1_arvalid = 1;
        exp_q.push_back({1'b0, 32'h24, 32'h0});
        exp_q.push_back({1'b0, 32'h34, 32'h0});
        mid;
        nxt;
        mid;
        check("t2_tie_s0", {state, grant}, {S_RA, 1'b0});
        finish_read(0, 2'b00);
        nxt;
        mid;
        check("t2_then_s1", {state, grant}, {S_RA, 1'b1});
        chk_quiet("t2_s0_quiet_rd", 0);
        finish_read(1, 2'b00);

        // s1: W three cycles before AW, slave AW ready delayed
        a0 = aw_hs_cnt;
        w0 = w_hs_cnt;
        nxt;
        d = $urandom;
        m_awready = 0;
        s1_awaddr = 32'h40; s1_wdata = d; s1_wstrb = 4'h3; s1_wvalid = 1;
        exp_q.push_back({1'b1, 32'h40, d});
        mid;
        nxt;
        mid;
        check("t3_wa", {state, grant}, {S_WA, 1'b1});
        check("t3_w_only", {m_awvalid, m_wvalid}, 2'b01);
        check("t3_wstrb", m_wstrb, 4'h3);
        check("t3_s1_wready", s1_wready, 1);
        nxt;
        mid;
        check("t3_w_done_gate", {m_wvalid, s1_wready}, 2'b00);
        nxt;
        s1_wvalid = 0;
        s1_awvalid = 1;
        mid;
        check("t3_aw_wait", {m_awvalid, s1_awready}, 2'b10);
        nxt;
        mid;
        check("t3_aw_wait2", {state, s1_awready}, {S_WA, 1'b0});
        nxt;
        m_awready = 1;
        mid;
        check("t3_aw_go", s1_awready, 1);
        finish_write(1, 2'b00);
        check("t3_aw_count", aw_hs_cnt - a0, 1);
        check("t3_w_count", w_hs_cnt - w0, 1);

        // s0 write and read pending together: write first
        nxt;
        d = $urandom;
        s0_awaddr = 32'h50; s0_awvalid = 1; s0_wdata = d; s0_wstrb = 4'hF; s0_wvalid = 1;
        s0_araddr = 32'h54; s0_arvalid = 1;
        exp_q.push_back({1'b1, 32'h50, d});
        exp_q.push_back({1'b0, 32'h54, 32'h0});
        mid;
        nxt;
        mid;
        check("t4_wr_first", {state, grant}, {S_WA, 1'b0});
        check("t4_no_ar", {m_arvalid, s0_arready}, 2'b00);
        chk_quiet("t4_s1_quiet_wa", 1);
        finish_write(0, 2'b00);
        check("t4_idle_no_ar", m_arvalid, 0);
        nxt;
        mid;
        check("t4_rd_next", {state, m_arvalid}, {S_RA, 1'b1});
        check("t4_araddr", m_araddr, 32'h54);
        chk_quiet("t4_s1_quiet_ra", 1);
        finish_read(0, 2'b00);

        // B backpressure from s0 while s1 waits with a read
        nxt;
        d = $urandom;
        s0_awaddr = 32'h60; s0_awvalid = 1; s0_wdata = d; s0_wvalid = 1; s0_bready = 0;
        exp_q.push_back({1'b1, 32'h60, d});
        mid;
        nxt;
        s1_araddr = 32'h70; s1_arvalid = 1;
        exp_q.push_back({1'b0, 32'h70, 32'h0});
        mid;
        check("t5_wa", {state, grant}, {S_WA, 1'b0});
        nxt;
        s0_awvalid = 0; s0_wvalid = 0;
        m_bvalid = 1; m_bresp = 2'b10;
        for (int i = 0; i < 4; i++) begin
            mid;
            check("t5_hold_state", state, S_WR);
            check("t5_hold_ctrl", {m_bready, s0_bvalid, s1_arready, m_arvalid}, 4'b0100);
            nxt;
        end
        s0_bready = 1;
        mid;
        check("t5_release", {state, m_bready, s0_bresp}, {S_WR, 1'b1, 2'b10});
        nxt;
        m_bvalid = 0;
        s0_bready = 0;
        mid;
        check("t5_idle", state, S_IDLE);
        nxt;
        mid;
        check("t5_s1_granted", {state, grant}, {S_RA, 1'b1});
        check("t5_araddr", m_araddr, 32'h70);

        // reset during RD_DATA
        nxt;
        s1_arvalid = 0;
        m_rvalid = 1;
        s1_rready = 0;
        mid;
        check("t6_rd", {state, s1_rvalid, m_rready}, {S_RD, 1'b1, 1'b0});
        nxt;
        areset = 1;
        mid;
        nxt;
        areset = 0;
        s1_rready = 1;
        mid;
        check("t6_state", state, S_IDLE);
        check("t6_grant_last", {grant, last}, 2'b01);
        check("t6_m_ctrl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        chk_quiet("t6_s1", 1);
        chk_quiet("t6_s0", 0);
        m_rvalid = 0;
        s1_rready = 0;
        nxt;
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
